// File: rtl/mgr_noc_locl_arb.sv
// Packet-granular round-robin arbiter sharing the manager-local NoC port between
// NUM_REQ local sources, with a one-entry registered output stage.
module mgr_noc_locl_arb #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned TYPE_W  = 2,
   parameter int unsigned PTYPE_W = 4,
   parameter int unsigned DEST_W  = 2,
   localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        reset_poweron,
   input  logic [NUM_REQ-1:0]          req__arb__valid,
   input  logic [2*NUM_REQ-1:0]        req__arb__cntl,
   output logic [NUM_REQ-1:0]          arb__req__ready,
   input  logic [TYPE_W*NUM_REQ-1:0]   req__arb__type,
   input  logic [PTYPE_W*NUM_REQ-1:0]  req__arb__ptype,
   input  logic [DEST_W*NUM_REQ-1:0]   req__arb__desttype,
   input  logic [NUM_REQ-1:0]          req__arb__pvalid,
   input  logic [DATA_W*NUM_REQ-1:0]   req__arb__data,
   output logic                        locl__noc__dp_valid,
   output logic [1:0]                  locl__noc__dp_cntl,
   input  logic                        noc__locl__dp_ready,
   output logic [TYPE_W-1:0]           locl__noc__dp_type,
   output logic [PTYPE_W-1:0]          locl__noc__dp_ptype,
   output logic [DEST_W-1:0]           locl__noc__dp_desttype,
   output logic                        locl__noc__dp_pvalid,
   output logic [DATA_W-1:0]           locl__noc__dp_data,
   output logic [IDX_W-1:0]            arb__grant_id,
   output logic                        arb__proto_err
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt, owner, owner_nxt;
   logic [IDX_W-1:0]   cand_idx, any_idx, sel;
   logic               cand_found, any_found;
   logic               space, grant_ok, take, drop, load, gid_load, err_set;
   logic [1:0]         sel_cntl;

   logic [1:0]         cntl_a  [NUM_REQ];
   logic [TYPE_W-1:0]  type_a  [NUM_REQ];
   logic [PTYPE_W-1:0] ptype_a [NUM_REQ];
   logic [DEST_W-1:0]  dest_a  [NUM_REQ];
   logic [DATA_W-1:0]  data_a  [NUM_REQ];

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
      return (v == IDX_W'(NUM_REQ - 1)) ? '0 : v + 1'b1;
   endfunction

   always_comb begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cntl_a[k]  = req__arb__cntl[2*k +: 2];
         type_a[k]  = req__arb__type[TYPE_W*k +: TYPE_W];
         ptype_a[k] = req__arb__ptype[PTYPE_W*k +: PTYPE_W];
         dest_a[k]  = req__arb__desttype[DEST_W*k +: DEST_W];
         data_a[k]  = req__arb__data[DATA_W*k +: DATA_W];
      end
   end

   assign space = !locl__noc__dp_valid || noc__locl__dp_ready;

   // Two rotating searches: SOM-bearing candidates, and any valid requester
   // (the latter only matters when a stray MOM/EOM has to be flushed).
   always_comb begin
      logic [IDX_W-1:0] idx;
      cand_found = 1'b0;
      cand_idx   = '0;
      any_found  = 1'b0;
      any_idx    = '0;
      idx        = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
         if (!cand_found && req__arb__valid[idx] && cntl_a[idx][0]) begin
            cand_found = 1'b1;
            cand_idx   = idx;
         end
         if (!any_found && req__arb__valid[idx]) begin
            any_found = 1'b1;
            any_idx   = idx;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      owner_nxt  = owner;
      gid_load   = 1'b0;
      err_set    = 1'b0;
      sel        = (state == LOCKED) ? owner : (cand_found ? cand_idx : any_idx);
      sel_cntl   = cntl_a[sel];
      grant_ok   = reset_poweron && space && (state == LOCKED || any_found);
      arb__req__ready      = '0;
      arb__req__ready[sel] = grant_ok;
      take = grant_ok && req__arb__valid[sel];
      drop = take && (state == IDLE) && !cand_found;
      load = take && !drop;
      if (state == IDLE) begin
         if (take && cand_found) begin
            gid_load = 1'b1;
            if (sel_cntl == 2'b11) begin
               rr_ptr_nxt = wrap_inc(sel);
            end else begin
               state_nxt = LOCKED;
               owner_nxt = sel;
            end
         end
         err_set = drop;
      end else if (take) begin
         err_set = sel_cntl[0];
         if (sel_cntl[1]) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = wrap_inc(owner);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         state                  <= IDLE;
         rr_ptr                 <= '0;
         owner                  <= '0;
         arb__grant_id          <= '0;
         arb__proto_err         <= 1'b0;
         locl__noc__dp_valid    <= 1'b0;
         locl__noc__dp_cntl     <= '0;
         locl__noc__dp_type     <= '0;
         locl__noc__dp_ptype    <= '0;
         locl__noc__dp_desttype <= '0;
         locl__noc__dp_pvalid   <= 1'b0;
         locl__noc__dp_data     <= '0;
      end else begin
         state  <= state_nxt;
         rr_ptr <= rr_ptr_nxt;
         owner  <= owner_nxt;
         if (gid_load) arb__grant_id <= sel;
         if (err_set) arb__proto_err <= 1'b1;
         if (load) begin
            locl__noc__dp_valid    <= 1'b1;
            locl__noc__dp_cntl     <= sel_cntl;
            locl__noc__dp_type     <= type_a[sel];
            locl__noc__dp_ptype    <= ptype_a[sel];
            locl__noc__dp_desttype <= dest_a[sel];
            locl__noc__dp_pvalid   <= req__arb__pvalid[sel];
            locl__noc__dp_data     <= data_a[sel];
         end else if (space) begin
            locl__noc__dp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mgr_noc_locl_arb.sv
// Directed bench for mgr_noc_locl_arb: per-cycle comparison against a packet-level
// arbitration model, plus literal checks of the NoC-side flit sequences.
module tb_mgr_noc_locl_arb;

   localparam int N  = 4;
   localparam int DW = 64;

   typedef struct packed {logic [1:0] c; logic [63:0] d;} flit_t;
   typedef struct {logic [63:0] data; logic [1:0] cntl; int gid; int cyc;} obs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset_poweron;
   logic [N-1:0]    valid, pval, rdy;
   logic [2*N-1:0]  cntl, typ, dest;
   logic [4*N-1:0]  ptyp;
   logic [DW*N-1:0] data;
   logic            dp_valid, dp_ready, dp_pvalid, err;
   logic [1:0]      dp_cntl, dp_type, dp_dest, gid;
   logic [3:0]      dp_ptype;
   logic [63:0]     dp_data;

   mgr_noc_locl_arb #(.NUM_REQ(N), .DATA_W(DW), .TYPE_W(2), .PTYPE_W(4), .DEST_W(2)) dut (
      .clk(clk), .reset_poweron(reset_poweron),
      .req__arb__valid(valid), .req__arb__cntl(cntl), .arb__req__ready(rdy),
      .req__arb__type(typ), .req__arb__ptype(ptyp), .req__arb__desttype(dest),
      .req__arb__pvalid(pval), .req__arb__data(data),
      .locl__noc__dp_valid(dp_valid), .locl__noc__dp_cntl(dp_cntl),
      .noc__locl__dp_ready(dp_ready), .locl__noc__dp_type(dp_type),
      .locl__noc__dp_ptype(dp_ptype), .locl__noc__dp_desttype(dp_dest),
      .locl__noc__dp_pvalid(dp_pvalid), .locl__noc__dp_data(dp_data),
      .arb__grant_id(gid), .arb__proto_err(err));

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   flit_t src_q [N][$];
   obs_t  seen [$];
   logic [N-1:0] pres  = '0;
   logic [N-1:0] rdy_s = '0;
   bit toggle = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Requesters: hold the head flit until it is seen accepted, then advance.
   always begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (pres[i] && rdy_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         if (src_q[i].size() > 0) begin
            valid[i]         = 1'b1;
            cntl[2*i +: 2]   = src_q[i][0].c;
            data[DW*i +: DW] = src_q[i][0].d;
            typ[2*i +: 2]    = 2'(i);
            ptyp[4*i +: 4]   = src_q[i][0].d[3:0];
            dest[2*i +: 2]   = src_q[i][0].d[5:4];
            pval[i]          = ~src_q[i][0].d[0];
         end else begin
            valid[i]       = 1'b0;
            cntl[2*i +: 2] = 2'b00;
         end
         pres[i] = valid[i];
      end
      if (toggle) dp_ready = ~dp_ready;
   end

   // Model: locked owner (-1 when idle), pointer, error flag, one output slot.
   int          m_owner = -1, m_ptr = 0, m_gid = 0;
   bit          m_err = 1'b0, m_valid = 1'b0;
   logic [1:0]  m_cntl, m_type, m_dest;
   logic [3:0]  m_ptype;
   logic        m_pval;
   logic [63:0] m_data;

   always begin
      int sel, j;
      bit take, drop, space;
      logic [N-1:0] e_rdy;
      logic [1:0] c;
      @(negedge clk);
      sel = -1; take = 0; drop = 0; space = 0; e_rdy = '0;
      if (!reset_poweron) begin
         m_owner = -1; m_ptr = 0; m_gid = 0; m_err = 0; m_valid = 0;
         chk("rst_dp_valid", dp_valid, 0);
         chk("rst_ready", rdy, 0);
         chk("rst_grant_id", gid, 0);
         chk("rst_proto_err", err, 0);
         chk("rst_dp_data", dp_data, 0);
      end else begin
         space = !m_valid || dp_ready;
         if (space) begin
            if (m_owner >= 0) sel = m_owner;
            else begin
               for (int k = 0; k < N; k++) begin
                  j = (m_ptr + k) % N;
                  if (sel < 0 && valid[j] && cntl[2*j]) sel = j;
               end
               for (int k = 0; k < N; k++) begin
                  j = (m_ptr + k) % N;
                  if (sel < 0 && valid[j]) begin sel = j; drop = 1; end
               end
            end
            if (sel >= 0) begin e_rdy[sel] = 1'b1; take = valid[sel]; end
         end
         chk("ready", rdy, e_rdy);
         chk("dp_valid", dp_valid, m_valid);
         if (m_valid) begin
            chk("dp_cntl", dp_cntl, m_cntl);
            chk("dp_data", dp_data, m_data);
            chk("dp_type", dp_type, m_type);
            chk("dp_ptype", dp_ptype, m_ptype);
            chk("dp_desttype", dp_dest, m_dest);
            chk("dp_pvalid", dp_pvalid, m_pval);
         end
         chk("grant_id", gid, m_gid);
         chk("proto_err", err, m_err);
         if (dp_valid && dp_ready) seen.push_back('{dp_data, dp_cntl, int'(gid), cyc});
      end
      rdy_s = rdy;
      @(posedge clk);
      cyc++;
      if (reset_poweron) begin
         if (space) begin
            if (take && !drop) begin
               m_valid = 1; m_cntl = cntl[2*sel +: 2]; m_data = data[DW*sel +: DW];
               m_type = typ[2*sel +: 2]; m_ptype = ptyp[4*sel +: 4];
               m_dest = dest[2*sel +: 2]; m_pval = pval[sel];
            end else m_valid = 0;
         end
         if (take) begin
            c = cntl[2*sel +: 2];
            if (m_owner < 0) begin
               if (drop) m_err = 1;
               else begin
                  m_gid = sel;
                  if (c == 2'b11) m_ptr = (sel + 1) % N;
                  else m_owner = sel;
               end
            end else begin
               if (c[0]) m_err = 1;
               if (c[1]) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
            end
         end
      end
   end

   function automatic bit all_empty();
      for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_idle(input string nm);
      bit done = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(posedge clk);
         #3;
         done = all_empty() && !dp_valid;
      end
      chk({nm, "_drained"}, done, 1);
   endtask

   task automatic check_obs(input string nm, input int idx, input logic [63:0] d,
                            input logic [1:0] c, input int g);
      if (idx < seen.size()) begin
         chk({nm, "_data"}, seen[idx].data, d);
         chk({nm, "_cntl"}, seen[idx].cntl, c);
         chk({nm, "_gid"}, seen[idx].gid, g);
      end else chk({nm, "_count"}, seen.size(), idx + 1);
   endtask

   task automatic push(input int i, input logic [1:0] c, input logic [63:0] d);
      src_q[i].push_back('{c, d});
   endtask

   initial begin
      bit hit;
      int exp_g [12];
      reset_poweron = 1'b0; valid = '0; cntl = '0; typ = '0; ptyp = '0; dest = '0;
      pval = '0; data = '0; dp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      reset_poweron = 1'b1;

      // Single 3-flit packet from requester 2.
      push(2, 2'b01, 64'hA0); push(2, 2'b00, 64'hA1); push(2, 2'b10, 64'hA2);
      wait_idle("t1");
      check_obs("t1_f0", 0, 64'hA0, 2'b01, 2);
      check_obs("t1_f1", 1, 64'hA1, 2'b00, 2);
      check_obs("t1_f2", 2, 64'hA2, 2'b10, 2);
      if (seen.size() == 3) chk("t1_back_to_back", seen[2].cyc - seen[0].cyc, 2);
      chk("t1_proto_err", err, 0);
      seen.delete();

      // All four streaming single-flit packets; pointer starts at 3.
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < N; i++) push(i, 2'b11, 64'h200 + 16*i + r);
      wait_idle("t2");
      exp_g = '{3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
      for (int k = 0; k < 12; k++)
         check_obs("t2", k, 64'h200 + 16*exp_g[k] + k/4, 2'b11, exp_g[k]);
      if (seen.size() == 12) chk("t2_no_bubbles", seen[11].cyc - seen[0].cyc, 11);
      seen.delete();

      // Locked packet from 0 while 1 waits, NoC ready toggling.
      toggle = 1'b1;
      push(0, 2'b01, 64'hB0); push(0, 2'b00, 64'hB1); push(0, 2'b00, 64'hB2);
      push(0, 2'b10, 64'hB3); push(1, 2'b11, 64'hC0);
      wait_idle("t3");
      toggle = 1'b0; dp_ready = 1'b1;
      check_obs("t3_b0", 0, 64'hB0, 2'b01, 0);
      check_obs("t3_b1", 1, 64'hB1, 2'b00, 0);
      check_obs("t3_b2", 2, 64'hB2, 2'b00, 0);
      check_obs("t3_b3", 3, 64'hB3, 2'b10, 0);
      check_obs("t3_c0", 4, 64'hC0, 2'b11, 1);
      chk("t3_count", seen.size(), 5);
      seen.delete();

      // Stray MOM while idle: swallowed, sticky error.
      push(3, 2'b00, 64'hD0);
      wait_idle("t4");
      chk("t4_forwarded", seen.size(), 0);
      chk("t4_proto_err", err, 1);
      repeat (3) @(posedge clk);
      #3;
      chk("t4_proto_err_sticky", err, 1);

      // Reset mid-packet.
      push(0, 2'b01, 64'hE0); push(0, 2'b00, 64'hE1); push(0, 2'b10, 64'hE2);
      hit = 1'b0;
      for (int n = 0; n < 20 && !hit; n++) begin
         @(posedge clk);
         #3;
         hit = (src_q[0].size() == 2);
      end
      chk("t5_som_taken", hit, 1);
      chk("t5_pre_valid", dp_valid, 1);
      reset_poweron = 1'b0;
      #1;
      chk("t5_async_valid", dp_valid, 0);
      chk("t5_async_gid", gid, 0);
      chk("t5_async_err", err, 0);
      chk("t5_async_ready", rdy, 0);
      chk("t5_async_data", dp_data, 0);
      for (int i = 0; i < N; i++) src_q[i].delete();
      seen.delete();
      repeat (2) @(posedge clk);
      #3;
      reset_poweron = 1'b1;
      push(1, 2'b11, 64'hF0);
      wait_idle("t5");
      check_obs("t5_f0", 0, 64'hF0, 2'b11, 1);
      chk("t5_count", seen.size(), 1);

      // Pointer wrap: bring pointer to 3, then 0 and 3 compete.
      push(2, 2'b11, 64'h60);
      wait_idle("t6a");
      seen.delete();
      push(0, 2'b11, 64'h70); push(3, 2'b11, 64'h73);
      wait_idle("t6");
      check_obs("t6_first", 0, 64'h73, 2'b11, 3);
      check_obs("t6_second", 1, 64'h70, 2'b11, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mgr_noc_locl_arb.md
Name: mgr_noc_locl_arb

Overview:
- Packet-granular round-robin arbiter sharing the single manager-local to NoC port (locl__noc__dp_*) between NUM_REQ local sources, e.g. WU decoder, return-data processor and memory-write controller.
- Grants one requester at SOM and holds the grant until that requester's EOM, so packets never interleave.
- Output passes through a one-entry registered stage that meets NoC valid/ready timing.

Parameters:
- NUM_REQ, 4, number of local requesters (2..8).
- DATA_W, 64, width of dp_data (matches MGR_NOC_CONT_INTERNAL_DATA range).
- TYPE_W, 2, packet type width; PTYPE_W, 4, payload type width; DEST_W, 2, destination type width.

Ports:
- clk  in  1  system clock.
- reset_poweron  in  1  asynchronous, active-low reset.
- req__arb__valid  in  NUM_REQ  per-requester flit valid.
- req__arb__cntl  in  2*NUM_REQ  per-requester cntl: SOM=01, MOM=00, EOM=10, SOM_EOM=11.
- arb__req__ready  out  NUM_REQ  per-requester accept.
- req__arb__type  in  TYPE_W*NUM_REQ  packet type.
- req__arb__ptype  in  PTYPE_W*NUM_REQ  payload type.
- req__arb__desttype  in  DEST_W*NUM_REQ  destination type.
- req__arb__pvalid  in  NUM_REQ  payload valid.
- req__arb__data  in  DATA_W*NUM_REQ  flit data.
- locl__noc__dp_valid  out  1  flit valid to NoC.
- locl__noc__dp_cntl  out  2  flit cntl.
- noc__locl__dp_ready  in  1  NoC accept.
- locl__noc__dp_type / _ptype / _desttype / _pvalid / _data  out  TYPE_W / PTYPE_W / DEST_W / 1 / DATA_W  registered flit fields.
- arb__grant_id  out  clog2(NUM_REQ)  current or last grantee.
- arb__proto_err  out  1  sticky protocol error.

Behaviour:
- Reset values (async, reset_poweron=0): all outputs 0, FSM=IDLE, round-robin pointer rr_ptr=0, arb__proto_err=0.
- Transfer rules:
  - A flit transfers on the requester side when req__arb__valid[i] & arb__req__ready[i].
  - A flit transfers on the NoC side when locl__noc__dp_valid & noc__locl__dp_ready.
- Output stage:
  - One register entry; space = !locl__noc__dp_valid | noc__locl__dp_ready, so simultaneous drain and fill gives 1 flit/cycle.
  - Latency is exactly 1 cycle, requester accept to locl__noc__dp_valid.
  - Output fields change only when a new flit loads. Once asserted, valid holds until NoC ready.
- arb__req__ready[i] = space & ((FSM==IDLE & i==winner) | (FSM==LOCKED & i==owner)). All other requesters see ready=0.
- FSM IDLE:
  - Candidates are requesters with valid=1 and cntl SOM or SOM_EOM.
  - winner = first candidate searching from rr_ptr upward, modulo NUM_REQ.
  - Accepting a SOM moves FSM to LOCKED, owner=winner.
  - Accepting a SOM_EOM stays in IDLE with rr_ptr=winner+1 (wraps NUM_REQ-1 -> 0).
  - No candidate: no grant, rr_ptr unchanged.
- FSM LOCKED:
  - Only owner is served. MOM flits pass through.
  - EOM accept returns FSM to IDLE, rr_ptr=owner+1 (wrap).
  - No EOM timeout; owner stalls are tolerated indefinitely.
  - The next packet can be granted the cycle after EOM accept, so there are no bubbles if the NoC is ready.
- Protocol errors: each sets arb__proto_err=1 and it stays set until reset.
  - IDLE with valid & cntl MOM/EOM on requester i: the flit is accepted only if i is the round-robin winner among all valid requesters, then dropped (not forwarded).
  - LOCKED with owner presenting SOM/SOM_EOM: forwarded unchanged.
- arb__grant_id updates on every SOM/SOM_EOM accept.
- NoC backpressure freezes everything: no grants, no pointer movement.
- Reset mid-packet: output flit discarded, FSM=IDLE. Requesters must restart at SOM.

Test Plan:
- Single requester 2 sends 3-flit packet (SOM,MOM,EOM, data 0xA0..0xA2), NoC ready=1 -> dp_valid cycles 1..3 after first accept, data A0,A1,A2, cntl 01,00,10; grant_id=2; rr_ptr=3.
- All 4 requesters continuously send SOM_EOM single-flit packets -> grant order 0,1,2,3,0,1... at 1 flit/cycle, no bubbles.
- Req0 holds 4-flit packet while req1 valid with SOM; NoC ready toggles 1,0,1,0 -> req1 is not granted until req0 EOM accept; no flit lost or duplicated; output held stable during ready=0.
- Req3 presents MOM while IDLE, no other valid -> flit accepted and dropped, dp_valid stays 0, proto_err=1 and stays 1.
- Assert reset_poweron=0 after SOM of a 3-flit packet -> all outputs 0 asynchronously. After release, a new SOM_EOM from req1 is forwarded with grant_id=1.
- Wrap: rr_ptr=3, requesters 0 and 3 valid with SOM_EOM -> order 3 then 0.
